// File: rtl/rng_share_pkg.sv
// Shared constants and helpers for the stochastic-computing RNG array:
// LFSR tap masks by width, the reset seed, and a width-aware rotate-left.
package rng_share_pkg;

    localparam int unsigned LfsrSeed  = 1;
    localparam int unsigned MaxRwid   = 16;

    // Bit i set means state bit i feeds the XOR; all polynomials are primitive.
    function automatic logic [MaxRwid-1:0] lfsr_tap_mask(input int unsigned width);
        logic [MaxRwid-1:0] mask;
        case (width)
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0E08;
            13:      mask = 16'h1C80;
            14:      mask = 16'h3802;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = '0;
        endcase
        return mask;
    endfunction

    // Rotates the low 'width' bits of v left by n; bits above 'width' read as zero.
    function automatic logic [MaxRwid-1:0] rotl(input logic [MaxRwid-1:0] v,
                                                  input int unsigned width,
                                                  input int unsigned n);
        logic [MaxRwid-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxRwid; i++) begin
            if (i < width) begin
                r[4'((i + n) % width)] = v[4'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rng_lfsr_core.sv
// Maximal-length Fibonacci LFSR, left-shifting; advances once per enabled cycle.
module rng_lfsr_core
    import rng_share_pkg::*;
#(
    parameter int unsigned RWID = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    output logic [RWID-1:0] state
);

    localparam logic [MaxRwid-1:0] TapMask = lfsr_tap_mask(RWID);
    localparam logic [RWID-1:0]    Seed    = RWID'(LfsrSeed);

    if (RWID < 3 || RWID > MaxRwid) begin : g_bad_width
        $error("rng_lfsr_core: RWID must be within 3..16");
    end

    logic [RWID-1:0] r_state;
    logic            w_fb;

    assign w_fb  = ^(r_state & TapMask[RWID-1:0]);
    assign state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= Seed;
        end else if (enable) begin
            r_state <= {r_state[RWID-2:0], w_fb};
        end
    end

endmodule

// File: rtl/rng_share_array.sv
// Shared RNG array: one LFSR fanned out through an SDIM-tap delay line, replicated into TDIM rows.
// Define RNG_SHARE_ROTATE_EN to rotate row b left by (b mod RWID) bits; otherwise rows are copies.
module rng_share_array
    import rng_share_pkg::*;
#(
    parameter int unsigned RWID = 8,
    parameter int          BDIM = 0,
    parameter int unsigned SDIM = 8,
    localparam int unsigned TDIM = (BDIM < 1) ? 1 : BDIM
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    output logic [RWID-1:0] rngSeq [TDIM*SDIM-1:0]
);

    logic [RWID-1:0] w_row0 [SDIM];

    rng_lfsr_core #(
        .RWID (RWID)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .state  (w_row0[0])
    );

    // Tap s holds the core output delayed by s enabled edges.
    for (genvar s = 1; s < SDIM; s++) begin : g_tap
        logic [RWID-1:0] r_tap;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tap <= '0;
            end else if (enable) begin
                r_tap <= w_row0[s-1];
            end
        end

        assign w_row0[s] = r_tap;
    end

    for (genvar b = 0; b < TDIM; b++) begin : g_row
        for (genvar s = 0; s < SDIM; s++) begin : g_col
`ifdef RNG_SHARE_ROTATE_EN
            assign rngSeq[b*SDIM+s] =
                RWID'(rotl(16'(w_row0[s]), RWID, unsigned'(b % RWID)));
`else
            assign rngSeq[b*SDIM+s] = w_row0[s];
`endif
        end
    end

endmodule

// File: tb/tb_rng_share_array.sv
// Scoreboard bench for rng_share_array (RWID=8, SDIM=8, BDIM=2); honours RNG_SHARE_ROTATE_EN.
module tb_rng_share_array;

    localparam int RWID = 8;
    localparam int SDIM = 8;
    localparam int BDIM = 2;
    localparam int NOUT = 16;

    typedef logic [NOUT-1:0][RWID-1:0] vec_t;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            enable = 1'b0;
    logic [RWID-1:0] rng_seq [NOUT-1:0];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] base_q[$];
    int         k;
    vec_t       exp_q[$];

    always #5 clk = ~clk;

    rng_share_array #(
        .RWID (RWID),
        .BDIM (BDIM),
        .SDIM (SDIM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .rngSeq (rng_seq)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    function automatic logic [7:0] rot_left1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] model_tap(input int s);
        if (k >= s) return base_q[k-s];
        return 8'h00;
    endfunction

    function automatic vec_t model_vec();
        vec_t e;
        for (int s = 0; s < SDIM; s++) begin
            e[s] = model_tap(s);
`ifdef RNG_SHARE_ROTATE_EN
            e[SDIM+s] = rot_left1(model_tap(s));
`else
            e[SDIM+s] = model_tap(s);
`endif
        end
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        base_q.delete();
        base_q.push_back(8'h01);
        k = 0;
    endtask

    task automatic compare_now();
        vec_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < NOUT; i++) begin
            check_eq($sformatf("rngSeq[%0d]", i), 32'(rng_seq[i]), 32'(e[i]));
        end
    endtask

    task automatic step(input logic en);
        enable = en;
        if (en) begin
            base_q.push_back(lfsr_step(base_q[k]));
            k++;
        end
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        compare_now();
    endtask

    initial begin
        logic [7:0] seq_tab [5];
        logic [255:0] seen;
        int dups;
        int zeros;
        logic [7:0] v;
        logic [7:0] frozen;

        seq_tab = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

        // Reset values while rst_n is low
        model_reset();
        #12;
        exp_q.push_back(model_vec());
        compare_now();
        check_eq("reset_seq0", 32'(rng_seq[0]), 32'h01);

        @(negedge clk);
        rst_n  = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1'b1);
            if (i <= 5) check_eq($sformatf("seq0_edge%0d", i), 32'(rng_seq[0]), 32'(seq_tab[i-1]));
            if (i == 4) begin
`ifdef RNG_SHARE_ROTATE_EN
                check_eq("row1_rot", 32'(rng_seq[8]), 32'h22);
`else
                check_eq("row1_copy", 32'(rng_seq[8]), 32'h11);
`endif
            end
            if (i == 6) check_eq("tap7_edge6", 32'(rng_seq[7]), 32'h00);
            if (i == 7) check_eq("tap7_edge7", 32'(rng_seq[7]), 32'h01);
        end

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(model_vec());
        #1;
        compare_now();
        check_eq("async_rst_seq0", 32'(rng_seq[0]), 32'h01);
        check_eq("async_rst_tap1", 32'(rng_seq[1]), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Full period from the seed
        seen  = '0;
        dups  = 0;
        zeros = 0;
        for (int i = 0; i < 255; i++) begin
            step(1'b1);
            v = rng_seq[0];
            if (v == 8'h00) zeros++;
            else if (seen[v]) dups++;
            seen[v] = 1'b1;
        end
        check_eq("period_wrap", 32'(rng_seq[0]), 32'h01);
        check_eq("period_distinct", 32'($countones(seen)), 32'd255);
        check_eq("period_dups", 32'(dups), 32'd0);
        check_eq("period_zeros", 32'(zeros), 32'd0);

        // Freeze and resume
        for (int i = 0; i < 40; i++) step(1'b1);
        frozen = base_q[k];
        for (int i = 0; i < 40; i++) step(1'b0);
        check_eq("freeze_hold", 32'(rng_seq[0]), 32'(frozen));
        step(1'b1);
        check_eq("resume_succ", 32'(rng_seq[0]), 32'(lfsr_step(frozen)));
        for (int i = 0; i < 4; i++) step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
